// File: rtl/rf_block_transfer_sequencer.sv
// Block load/store sequencer: walks a 16-bit register list. Each cycle it issues
// one register-file access and one memory access, then optionally writes the
// final address back to the base register.
module rf_block_transfer_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [3:0]        base_reg,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_val,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_pd,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_c,
  output logic [DATA_W-1:0] rf_pw,
  output logic              rf_ld,
  output logic [3:0]        rf_sd,
  output logic              hz_pcld,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [DATA_W-1:0] STEP   = DATA_W'(WORD_BYTES);
  localparam logic [3:0]        PC_REG = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // latched operands and walking state
  logic [15:0]       mask_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] final_q;
  logic              load_q;
  logic              wb_q;
  logic [3:0]        base_q;

  // values derived from the start operands
  logic [4:0]        list_cnt;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] first_addr;
  logic [DATA_W-1:0] final_nxt;
  logic              wb_nxt;

  // values derived from the walking mask
  logic [3:0]        cur_idx;
  logic              last_bit;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Memory write data always mirrors the register file store port.
  assign mem_wdata = rf_pd;

  // Start-time address arithmetic; the lowest register always gets the lowest address.
  always_comb begin
    list_cnt  = popcount16(reg_list);
    span      = DATA_W'(list_cnt) * STEP;
    final_nxt = up ? (base_val + span) : (base_val - span);
    case ({up, pre})
      2'b11:   first_addr = base_val + STEP;
      2'b10:   first_addr = base_val;
      2'b01:   first_addr = base_val - span;
      default: first_addr = base_val - span + STEP;
    endcase
    // A loaded base register takes precedence over the writeback value.
    wb_nxt = wback & ~(is_load & reg_list[base_reg]);
  end

  // Current register index and end-of-list detection.
  always_comb begin
    cur_idx  = lowest_idx(mask_q);
    last_bit = ((mask_q & (mask_q - 16'd1)) == 16'd0);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (list_cnt == 5'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (last_bit) state_nxt = wb_q ? S_WB : S_DONE;
      end
      S_WB:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on start, then walk the mask and address one word per transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q  <= 16'd0;
      addr_q  <= '0;
      final_q <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      base_q  <= 4'd0;
    end else if ((state == S_IDLE) && start) begin
      mask_q  <= reg_list;
      addr_q  <= first_addr;
      final_q <= final_nxt;
      load_q  <= is_load;
      wb_q    <= wb_nxt;
      base_q  <= base_reg;
    end else if (state == S_XFER) begin
      mask_q  <= mask_q & (mask_q - 16'd1);
      addr_q  <= addr_q + STEP;
    end
  end

  // Output decode from state and registers; load data passes straight from memory.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rf_c     = 4'd0;
    rf_pw    = '0;
    rf_ld    = 1'b0;
    rf_sd    = 4'd0;
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    case (state)
      S_XFER: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = addr_q;
        if (load_q) begin
          rf_c  = cur_idx;
          rf_pw = mem_rdata;
          rf_ld = 1'b1;
        end else begin
          mem_rw = 1'b1;
          rf_sd  = cur_idx;
        end
      end
      S_WB: begin
        busy  = 1'b1;
        rf_c  = base_q;
        rf_pw = final_q;
        rf_ld = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    // PC only loads when idle or when the PC itself is the RF write target.
    hz_pcld = (state == S_IDLE) | (rf_ld & (rf_c == PC_REG));
  end

endmodule
